// File: rtl/flash_bus_ctrl.sv
// Parallel NOR flash bus sequencer: one read or write bus cycle per fb_start,
// with programmable access/setup/pulse/hold/recovery timing in clock cycles.
module flash_bus_ctrl #(
  parameter int T_RD  = 6,
  parameter int T_WS  = 1,
  parameter int T_WP  = 3,
  parameter int T_WH  = 1,
  parameter int T_REC = 2
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic       fb_start,
  input  logic       FL_FLOW,
  input  logic [7:0] FL_ADDR,
  input  logic [7:0] fl_data_out,
  output logic [7:0] fl_data_in,
  output logic       fb_done,
  output logic       busy,
  output logic       SF_CE_N,
  output logic       SF_OE_N,
  output logic       SF_WE_N,
  output logic [7:0] SF_A,
  inout  wire  [7:0] SF_D
);

  // Zero-valued timings are stretched to one cycle so every state is visited.
  localparam int TRD_E  = (T_RD  < 1) ? 1 : T_RD;
  localparam int TWS_E  = (T_WS  < 1) ? 1 : T_WS;
  localparam int TWP_E  = (T_WP  < 1) ? 1 : T_WP;
  localparam int TWH_E  = (T_WH  < 1) ? 1 : T_WH;
  localparam int TREC_E = (T_REC < 1) ? 1 : T_REC;
  localparam int M1     = (TRD_E > TWS_E) ? TRD_E : TWS_E;
  localparam int M2     = (TWP_E > TWH_E) ? TWP_E : TWH_E;
  localparam int M3     = (M1 > M2) ? M1 : M2;
  localparam int MAXP   = (M3 > TREC_E) ? M3 : TREC_E;
  localparam int CW     = (MAXP < 2) ? 1 : $clog2(MAXP);

  // Counter is loaded with (cycles-1) on state entry and the state exits at zero.
  localparam logic [CW-1:0] RD_N  = CW'(TRD_E - 1);
  localparam logic [CW-1:0] WS_N  = CW'(TWS_E - 1);
  localparam logic [CW-1:0] WP_N  = CW'(TWP_E - 1);
  localparam logic [CW-1:0] WH_N  = CW'(TWH_E - 1);
  localparam logic [CW-1:0] REC_N = CW'(TREC_E - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ACCESS, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RECOVER
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    wdata;
  logic          d_oe;

  assign SF_D = d_oe ? wdata : 8'hzz;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      fl_data_in <= '0;
      fb_done    <= 1'b0;
      busy       <= 1'b0;
      SF_CE_N    <= 1'b1;
      SF_OE_N    <= 1'b1;
      SF_WE_N    <= 1'b1;
      SF_A       <= '0;
      wdata      <= '0;
      d_oe       <= 1'b0;
    end else begin
      fb_done <= 1'b0;
      case (state)
        IDLE: if (fb_start) begin
          SF_A    <= FL_ADDR;
          wdata   <= fl_data_out;
          busy    <= 1'b1;
          SF_CE_N <= 1'b0;
          if (FL_FLOW) begin
            state <= WR_SETUP;
            cnt   <= WS_N;
            d_oe  <= 1'b1;
          end else begin
            state   <= RD_ACCESS;
            cnt     <= RD_N;
            SF_OE_N <= 1'b0;
          end
        end
        RD_ACCESS:
          if (cnt == '0) state <= RD_LATCH;
          else           cnt   <= cnt - 1'b1;
        RD_LATCH: begin
          fl_data_in <= SF_D;
          SF_CE_N    <= 1'b1;
          SF_OE_N    <= 1'b1;
          fb_done    <= 1'b1;
          state      <= DONE;
        end
        WR_SETUP:
          if (cnt == '0) begin
            state   <= WR_PULSE;
            cnt     <= WP_N;
            SF_WE_N <= 1'b0;
          end else cnt <= cnt - 1'b1;
        WR_PULSE:
          if (cnt == '0) begin
            state   <= WR_HOLD;
            cnt     <= WH_N;
            SF_WE_N <= 1'b1;
          end else cnt <= cnt - 1'b1;
        WR_HOLD:
          if (cnt == '0) begin
            state   <= DONE;
            SF_CE_N <= 1'b1;
            d_oe    <= 1'b0;
            fb_done <= 1'b1;
          end else cnt <= cnt - 1'b1;
        DONE: begin
          state <= RECOVER;
          cnt   <= REC_N;
        end
        RECOVER:
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_bus_ctrl.sv
// Directed bench for flash_bus_ctrl with a byte-wide flash model on SF_*.
module tb_flash_bus_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fb_start = 1'b0;
  logic       fl_flow = 1'b0;
  logic [7:0] fl_addr = 8'h00;
  logic [7:0] fl_data_out = 8'h00;
  logic [7:0] fl_data_in;
  logic       fb_done, busy, sf_ce_n, sf_oe_n, sf_we_n;
  logic [7:0] sf_a;
  wire  [7:0] sf_d;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int ce_run = 0;
  int last_gap = 0;

  always #10 clk = ~clk;

  flash_bus_ctrl dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .fb_start(fb_start), .FL_FLOW(fl_flow),
    .FL_ADDR(fl_addr), .fl_data_out(fl_data_out), .fl_data_in(fl_data_in),
    .fb_done(fb_done), .busy(busy), .SF_CE_N(sf_ce_n), .SF_OE_N(sf_oe_n),
    .SF_WE_N(sf_we_n), .SF_A(sf_a), .SF_D(sf_d)
  );

  // Flash model: drives data while CE/OE low, stores whatever is on the bus while WE low.
  logic [7:0] mem [256];
  bit seeded = 1'b0;
  assign sf_d = (!sf_ce_n && !sf_oe_n) ? mem[sf_a] : 8'hzz;
  always @(posedge clk) begin
    if (!seeded) begin
      mem[8'h3C] <= 8'hA5;
      seeded     <= 1'b1;
    end else if (!sf_ce_n && !sf_we_n) mem[sf_a] <= sf_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle bus rules; contention with the model shows up as X on SF_D.
  always @(negedge clk) if (mon_en) begin
    chk("oe_we_excl", {31'b0, !(!sf_oe_n && !sf_we_n)}, 32'd1);
    if (!sf_oe_n) chk("no_drive_rd", {31'b0, (^sf_d !== 1'bx)}, 32'd1);
    if (sf_ce_n) begin
      chk("ce_hi_z", {31'b0, (sf_d === 8'hzz)}, 32'd1);
      ce_run++;
    end else if (ce_run > 0) begin
      last_gap = ce_run;
      ce_run   = 0;
    end
  end

  // Called at the negedge where fb_start was raised; k counts rising edges from the accepting one.
  task automatic observe(input int p1, input int p2, input logic [7:0] wexp,
                         output int done_at, output int done_cnt, output int oe_low,
                         output int we_low, output int d_match, output int idle_at);
    done_at = 0; done_cnt = 0; oe_low = 0; we_low = 0; d_match = 0; idle_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      fb_start = (k == p1) || (k == p2);
      if (k == 1) begin
        fl_addr     = 8'h99;
        fl_data_out = 8'hFF;
        fl_flow     = ~fl_flow;
      end
      if (!sf_oe_n) oe_low++;
      if (!sf_we_n) we_low++;
      if (!sf_ce_n && sf_d === wexp) d_match++;
      if (fb_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
  endtask

  task automatic start(input logic flow, input logic [7:0] addr, input logic [7:0] data);
    fl_flow = flow; fl_addr = addr; fl_data_out = data; fb_start = 1'b1;
  endtask

  int done_at, done_cnt, oe_low, we_low, d_match, idle_at;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ce", {31'b0, sf_ce_n}, 32'd1);
    chk("rst_oe", {31'b0, sf_oe_n}, 32'd1);
    chk("rst_we", {31'b0, sf_we_n}, 32'd1);
    chk("rst_a", {24'b0, sf_a}, 32'h00);
    chk("rst_din", {24'b0, fl_data_in}, 32'h00);
    chk("rst_busy_done", {30'b0, busy, fb_done}, 32'd0);
    chk("rst_d_z", {31'b0, (sf_d === 8'hzz)}, 32'd1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Read 0x3C; inputs are scrambled right after acceptance.
    start(1'b0, 8'h3C, 8'h00);
    observe(0, 0, 8'h00, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("rd_done_at", done_at, 8);
    chk("rd_done_cnt", done_cnt, 1);
    chk("rd_oe_low", oe_low, 7);
    chk("rd_we_low", we_low, 0);
    chk("rd_idle_at", idle_at, 11);
    chk("rd_data", {24'b0, fl_data_in}, 32'hA5);
    chk("rd_a_hold", {24'b0, sf_a}, 32'h3C);

    // Write 0x5A to 0x10.
    @(negedge clk);
    start(1'b1, 8'h10, 8'h5A);
    observe(0, 0, 8'h5A, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("wr_done_at", done_at, 6);
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_we_low", we_low, 3);
    chk("wr_oe_low", oe_low, 0);
    chk("wr_d_cycles", d_match, 5);
    chk("wr_idle_at", idle_at, 9);
    chk("wr_mem", {24'b0, mem[8'h10]}, 32'h5A);
    chk("wr_din_keep", {24'b0, fl_data_in}, 32'hA5);
    chk("wr_a_hold", {24'b0, sf_a}, 32'h10);

    // Stray starts during RD_ACCESS and RECOVER are ignored.
    @(negedge clk);
    start(1'b0, 8'h3C, 8'h00);
    observe(2, 9, 8'h00, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("rej_done_cnt", done_cnt, 1);
    chk("rej_done_at", done_at, 8);
    chk("rej_idle_at", idle_at, 11);

    // Accepted on the first idle cycle; then read it back on the next idle cycle.
    start(1'b1, 8'h01, 8'h77);
    observe(0, 0, 8'h77, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("b2b_wr_done_at", done_at, 6);
    chk("b2b_wr_idle_at", idle_at, 9);
    start(1'b0, 8'h01, 8'h00);
    observe(0, 0, 8'h00, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("b2b_rd_done_at", done_at, 8);
    chk("b2b_rd_data", {24'b0, fl_data_in}, 32'h77);
    chk("b2b_ce_gap", {31'b0, (last_gap >= 3)}, 32'd1);

    // Reset during WR_PULSE.
    @(negedge clk);
    start(1'b1, 8'h20, 8'h33);
    @(negedge clk);
    fb_start = 1'b0;
    @(negedge clk);
    chk("mid_we_low", {31'b0, sf_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, sf_we_n}, 32'd1);
    chk("mid_rst_ce", {31'b0, sf_ce_n}, 32'd1);
    chk("mid_rst_d_z", {31'b0, (sf_d === 8'hzz)}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_din", {24'b0, fl_data_in}, 32'h00);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (fb_done) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 0);

    // Release reset with a request already waiting: taken on the first rising edge.
    rst_n = 1'b1;
    start(1'b0, 8'h10, 8'h00);
    observe(0, 0, 8'h00, done_at, done_cnt, oe_low, we_low, d_match, idle_at);
    chk("post_rst_done_at", done_at, 8);
    chk("post_rst_data", {24'b0, fl_data_in}, 32'h5A);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_bus_ctrl.md
FLASH_BUS_CTRL -- requirements
Module: flash_bus_ctrl

Interface
REQ-001 The block SHALL have parameter T_RD, default 6, meaning read access cycles with CE/OE low before data sampling (120 ns at 50 MHz).
REQ-002 The block SHALL have parameter T_WS, default 1, meaning write setup cycles: address and data valid, WE high.
REQ-003 The block SHALL have parameter T_WP, default 3, meaning WE low pulse cycles.
REQ-004 The block SHALL have parameter T_WH, default 1, meaning write hold cycles: WE high, address and data still driven.
REQ-005 The block SHALL have parameter T_REC, default 2, meaning recovery cycles with CE high between bus cycles.
REQ-006 The block SHALL have port CLK_50MHZ, input, width 1: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port RST_N, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port fb_start, input, width 1: one-cycle request strobe from the flash manager.
REQ-009 The block SHALL have port FL_FLOW, input, width 1: direction, 1 = write, 0 = read; sampled with fb_start.
REQ-010 The block SHALL have port FL_ADDR, input, width 8: flash byte address; sampled with fb_start.
REQ-011 The block SHALL have port fl_data_out, input, width 8: write data; sampled with fb_start.
REQ-012 The block SHALL have port fl_data_in, output, width 8: registered read data, held until the next completed read.
REQ-013 The block SHALL have port fb_done, output, width 1: one-cycle completion pulse.
REQ-014 The block SHALL have port busy, output, width 1: high from the accepting edge until recovery ends.
REQ-015 The block SHALL have port SF_CE_N, output, width 1: flash chip enable, active-low.
REQ-016 The block SHALL have port SF_OE_N, output, width 1: flash output enable, active-low.
REQ-017 The block SHALL have port SF_WE_N, output, width 1: flash write enable, active-low.
REQ-018 The block SHALL have port SF_A, output, width 8: flash address bus.
REQ-019 The block SHALL have port SF_D, inout, width 8: flash data bus; driven only during write states, otherwise high-Z.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, RD_ACCESS, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RECOVER.
REQ-021 In IDLE, fb_start=1 SHALL register FL_FLOW, FL_ADDR and fl_data_out, then go to RD_ACCESS (flow 0) or WR_SETUP (flow 1).
REQ-022 All SF_* controls, SF_A and the SF_D output enable SHALL be registered outputs (no combinational glitches).
REQ-023 RD_ACCESS SHALL last T_RD cycles with SF_CE_N=0, SF_OE_N=0, SF_WE_N=1 and SF_A = latched address.
REQ-024 RD_LATCH SHALL last 1 cycle, keep CE/OE low, and capture SF_D into fl_data_in at its closing edge.
REQ-025 WR_SETUP SHALL last T_WS cycles with CE_N=0, OE_N=1, WE_N=1, and SF_A and SF_D driven.
REQ-026 WR_PULSE SHALL last T_WP cycles identical to WR_SETUP except WE_N=0.
REQ-027 WR_HOLD SHALL last T_WH cycles identical to WR_SETUP.
REQ-028 OE_N and WE_N SHALL never be low simultaneously.
REQ-029 SF_D SHALL never be driven while OE_N=0.
REQ-030 DONE SHALL last 1 cycle with CE_N=1, OE_N=1, WE_N=1, SF_D high-Z and fb_done=1, then go to RECOVER.
REQ-031 fb_done SHALL equal 1 only in DONE.
REQ-032 Read latency: fb_done SHALL rise T_RD+2 cycles after the accepting edge (8 at defaults).
REQ-033 Write latency: fb_done SHALL rise T_WS+T_WP+T_WH+1 cycles after the accepting edge (6 at defaults).
REQ-034 RECOVER SHALL last T_REC cycles with all controls inactive, then go to IDLE.
REQ-035 busy SHALL be 0 only in IDLE.
REQ-036 fb_start SHALL be ignored in every state other than IDLE; no queuing.
REQ-037 Input changes after acceptance SHALL have no effect on the cycle in progress.
REQ-038 Writes SHALL leave fl_data_in unchanged.
REQ-039 SF_A SHALL hold its last value after a cycle ends.
REQ-040 A single wait-cycle counter SHALL be sized for the largest timing parameter.
REQ-041 Any parameter set to 0 SHALL be treated as 1.

Reset
REQ-042 RST_N=0 SHALL, asynchronously, force state IDLE, counter 0, fl_data_in=0, fb_done=0, busy=0, SF_CE_N=1, SF_OE_N=1, SF_WE_N=1, SF_A=0 and SF_D high-Z.
REQ-043 Reset mid-cycle SHALL abort the cycle with no fb_done.
REQ-044 After reset release, the block SHALL accept fb_start on the first rising edge.

Verification
REQ-045 Read: flash model returns 0xA5 at 0x3C; pulse fb_start, FL_FLOW=0, FL_ADDR=0x3C -> OE_N low 7 cycles, fb_done pulse 8 cycles later, fl_data_in=0xA5, SF_D never driven.
REQ-046 Write: FL_FLOW=1, FL_ADDR=0x10, fl_data_out=0x5A -> WE_N low exactly 3 cycles, SF_D=0x5A from setup through hold, fb_done 6 cycles later; model stores 0x5A; fl_data_in unchanged.
REQ-047 Busy rejection: second fb_start during a read and during RECOVER -> ignored, exactly one fb_done; next fb_start accepted once busy=0.
REQ-048 Reset mid-write: RST_N low during WR_PULSE -> WE_N=1, CE_N=1, SF_D high-Z immediately; no fb_done; fl_data_in=0x00.
REQ-049 Back-to-back: write 0x77 to 0x01, then read 0x01 issued on the first cycle busy=0 -> fl_data_in=0x77; a CE_N-high gap of at least 3 cycles between the two accesses.
REQ-050 The bench SHALL assert REQ-028 and REQ-029 on every cycle of every scenario.
